// File: rtl/address_reader_en_if.sv
// Read-address bus for address_reader_en.
//
// Groups the writer strobe, the consumer handshake and the status flag seen
// by the read-side address generator. clock and reset stay plain ports on
// the module.
//
//   wr_enable  : writer's enable strobe, one pulse per word written
//   rd_ready   : consumer accepts the current address this cycle
//   clear_err  : clears the sticky overrun flag
//   rd_valid   : rd_address holds a buffered, unread word
//   rd_address : read address for the buffer memory
//   overrun    : sticky, writer wrote into a full buffer
//   level      : registered occupancy (only with ADDRESS_READER_LEVEL_OUT_EN)
//
// master = the side driving strobe/handshake (writer + consumer),
// slave  = the address generator.
interface address_reader_en_if #(
  parameter int bitwidth = 5
);
  logic                wr_enable;
  logic                rd_ready;
  logic                clear_err;
  logic                rd_valid;
  logic [bitwidth-1:0] rd_address;
  logic                overrun;
`ifdef ADDRESS_READER_LEVEL_OUT_EN
  logic [bitwidth:0]   level;

  modport master (
    output wr_enable, rd_ready, clear_err,
    input  rd_valid, rd_address, overrun, level
  );

  modport slave (
    input  wr_enable, rd_ready, clear_err,
    output rd_valid, rd_address, overrun, level
  );
`else
  modport master (
    output wr_enable, rd_ready, clear_err,
    input  rd_valid, rd_address, overrun
  );

  modport slave (
    input  wr_enable, rd_ready, clear_err,
    output rd_valid, rd_address, overrun
  );
`endif
endinterface

// File: rtl/address_reader_en.sv
// address_reader_en
//
// Read-side address generator for a circular buffer filled by the
// enable-driven write address generator. The writer's pointer is mirrored by
// counting its enable strobes; read addresses 0..MaxAddress-1 are issued with
// wrap-around under a valid/ready handshake. Streaming starts (and restarts
// after draining) only once Threshold words are buffered. A write into a full
// buffer raises a sticky overrun flag.
//
// Ports:
//   clock  : system clock, rising edge
//   reset  : synchronous, active-high
//   bus    : address_reader_en_if.slave (wr_enable, rd_ready, clear_err in;
//            rd_valid, rd_address, overrun out; level out when enabled)
//
// Optional feature macro: ADDRESS_READER_LEVEL_OUT_EN
//   defined   -> bus.level exposes the registered occupancy
//   undefined -> occupancy stays internal
module address_reader_en #(
  parameter int MaxAddress = 20,
  parameter int bitwidth   = 5,
  parameter int Threshold  = 4
) (
  input logic               clock,
  input logic               reset,
  address_reader_en_if.slave bus
);

  localparam int LW = bitwidth + 1;
  localparam logic [LW-1:0] MAX_LEVEL = LW'(MaxAddress);
  localparam logic [LW-1:0] THRESH    = LW'(Threshold);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [LW-1:0]       level;
  logic [LW-1:0]       level_nxt;
  logic [bitwidth-1:0] rd_address;
  logic                wr_enable_d;
  logic                overrun;
  logic                rd_valid;
  logic                rd_fire;
  logic                full;
  logic                ovr_set;
  logic                write_cnt;

  // Address increment with wrap: the compare is done one bit wider so that
  // MaxAddress == 2^bitwidth still wraps correctly.
  function automatic logic [bitwidth-1:0] wrap_inc(input logic [bitwidth-1:0] a);
    logic [LW-1:0] inc;
    inc = {1'b0, a} + LW'(1);
    if (inc == MAX_LEVEL) begin
      wrap_inc = '0;
    end else begin
      wrap_inc = inc[bitwidth-1:0];
    end
  endfunction

  // Occupancy update; a write into a full buffer with no concurrent read is
  // dropped, so level saturates at MaxAddress.
  function automatic logic [LW-1:0] level_update(input logic [LW-1:0] lvl,
                                                 input logic          wr,
                                                 input logic          rd);
    level_update = lvl + LW'(wr) - LW'(rd);
  endfunction

  // Decode and next-state: rd_valid is combinational from registered state so
  // the consumer sees a zero-cycle response to rd_ready.
  always_comb begin
    rd_valid  = (state == STREAM) && (level != '0);
    rd_fire   = rd_valid && bus.rd_ready;
    full      = (level == MAX_LEVEL);
    ovr_set   = wr_enable_d && full && !rd_fire;
    write_cnt = wr_enable_d && !ovr_set;
    level_nxt = level_update(level, write_cnt, rd_fire);
    state_nxt = state;
    case (state)
      IDLE:    if (level_nxt >= THRESH) state_nxt = STREAM;
      STREAM:  if (level_nxt == '0)     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Register stage: wr_enable_d lags the strobe by one cycle to track the
  // writer's own address-register lag.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      level       <= '0;
      wr_enable_d <= 1'b0;
      rd_address  <= '0;
      overrun     <= 1'b0;
    end else begin
      state       <= state_nxt;
      level       <= level_nxt;
      wr_enable_d <= bus.wr_enable;
      if (rd_fire) begin
        rd_address <= wrap_inc(rd_address);
      end
      if (ovr_set) begin
        overrun <= 1'b1;
      end else if (bus.clear_err) begin
        overrun <= 1'b0;
      end
    end
  end

  assign bus.rd_valid   = rd_valid;
  assign bus.rd_address = rd_address;
  assign bus.overrun    = overrun;
`ifdef ADDRESS_READER_LEVEL_OUT_EN
  assign bus.level      = level;
`endif

endmodule

// File: tb/tb_address_reader_en.sv
// Self-checking bench for address_reader_en: directed scenarios followed by
// randomized traffic, all compared against a word-counting reference model.
module tb_address_reader_en;

  localparam int MaxAddress = 20;
  localparam int bitwidth   = 5;
  localparam int Threshold  = 4;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  address_reader_en_if #(.bitwidth(bitwidth)) bus ();

  address_reader_en #(
    .MaxAddress(MaxAddress),
    .bitwidth  (bitwidth),
    .Threshold (Threshold)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  int checks = 0;
  int passed = 0;
  int failed = 0;

  // Reference model: occupancy as a word count, read pointer as an index
  // modulo the depth, a one-cycle-delayed strobe, and a primed flag.
  int m_level  = 0;
  int m_rdptr  = 0;
  bit m_ovr    = 1'b0;
  bit m_pend   = 1'b0;
  bit m_stream = 1'b0;

  function automatic bit m_valid();
    return m_stream && (m_level > 0);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input bit we, input bit rr, input bit ce, input bit rs);
    bit fire;
    bit full;
    bit set;
    bus.wr_enable = we;
    bus.rd_ready  = rr;
    bus.clear_err = ce;
    reset         = rs;
    fire = m_valid() && rr;
    full = (m_level == MaxAddress);
    set  = m_pend && full && !fire;
    @(posedge clock);
    if (rs) begin
      m_level  = 0;
      m_rdptr  = 0;
      m_ovr    = 1'b0;
      m_pend   = 1'b0;
      m_stream = 1'b0;
    end else begin
      if (ce)             m_ovr = 1'b0;
      if (set)            m_ovr = 1'b1;
      if (m_pend && !set) m_level = m_level + 1;
      if (fire) begin
        m_level = m_level - 1;
        m_rdptr = (m_rdptr + 1) % MaxAddress;
      end
      if (!m_stream && m_level >= Threshold) m_stream = 1'b1;
      else if (m_stream && m_level == 0)     m_stream = 1'b0;
      m_pend = we;
    end
    #1;
    check("model_valid", bus.rd_valid, m_valid());
    check("model_addr", bus.rd_address, m_rdptr);
    check("model_ovr", bus.overrun, m_ovr);
`ifdef ADDRESS_READER_LEVEL_OUT_EN
    check("model_level", bus.level, m_level);
`endif
  endtask

  initial begin
    int n;
    bus.wr_enable = 1'b0;
    bus.rd_ready  = 1'b0;
    bus.clear_err = 1'b0;
    reset         = 1'b1;

    // Reset with strobe and ready held high
    step(1, 1, 0, 1);
    step(1, 1, 0, 1);
    check("rst_addr", bus.rd_address, 0);
    check("rst_valid", bus.rd_valid, 0);
    check("rst_ovr", bus.overrun, 0);
`ifdef ADDRESS_READER_LEVEL_OUT_EN
    check("rst_level", bus.level, 0);
`endif

    // Priming: three pulses are not enough
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0, 0);
      step(0, 1, 0, 0);
    end
    step(0, 1, 0, 0);
    check("prime_hold", bus.rd_valid, 0);
    step(1, 1, 0, 0);
    check("prime_n1", bus.rd_valid, 0);
    step(0, 1, 0, 0);
    check("prime_n2", bus.rd_valid, 1);
    for (int i = 0; i < 4; i++) begin
      check("prime_addr", bus.rd_address, i);
      step(0, 1, 0, 0);
    end
    check("prime_idle", bus.rd_valid, 0);

    // Wrap: continuous write and read
    step(0, 0, 0, 1);
    n = 0;
    for (int k = 0; k < 80 && n < 25; k++) begin
      if (bus.rd_valid === 1'b1) begin
        check("wrap_addr", bus.rd_address, n % MaxAddress);
        n++;
      end
      step(1, 1, 0, 0);
    end
    check("wrap_count", n, 25);
    check("wrap_ovr", bus.overrun, 0);

    // Overrun: 21 writes with no reads
    step(0, 0, 0, 1);
    for (int i = 0; i < 21; i++) step(1, 0, 0, 0);
    check("ovr_early", bus.overrun, 0);
    step(0, 0, 0, 0);
    check("ovr_set", bus.overrun, 1);
    check("ovr_addr", bus.rd_address, 0);
    step(0, 0, 1, 0);
    check("ovr_clear", bus.overrun, 0);
`ifdef ADDRESS_READER_LEVEL_OUT_EN
    check("ovr_level", bus.level, MaxAddress);
`endif

    // Full buffer with simultaneous write and read
    step(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      check("full_addr", bus.rd_address, i);
      step(1, 1, 0, 0);
    end
    check("full_ovr", bus.overrun, 0);
    check("full_addr_end", bus.rd_address, 5);
`ifdef ADDRESS_READER_LEVEL_OUT_EN
    check("full_level", bus.level, MaxAddress);
`endif

    // Mid-stream reset
    step(0, 0, 0, 1);
    for (int k = 0; k < 60 && bus.rd_address !== 5'd7; k++) step(1, 1, 0, 0);
    step(0, 0, 0, 0);
    check("mid_addr", bus.rd_address, 7);
`ifdef ADDRESS_READER_LEVEL_OUT_EN
    check("mid_level", bus.level, 5);
`endif
    step(1, 1, 1, 1);
    check("mid_rst_addr", bus.rd_address, 0);
    check("mid_rst_valid", bus.rd_valid, 0);
    check("mid_rst_ovr", bus.overrun, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0, 0);
      step(0, 1, 0, 0);
    end
    step(0, 1, 0, 0);
    check("mid_reprime_hold", bus.rd_valid, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    check("mid_reprime_valid", bus.rd_valid, 1);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 1)),
           1'($urandom_range(0, 99) < 45),
           1'($urandom_range(0, 15) == 0),
           1'($urandom_range(0, 127) == 0));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
